pipe_hazard_ctrl: RTL and testbench

//  Parametrised, stateful hazard/pipeline-control unit for the pipelined CPU.

---
 rtl/pipe_hazard_ctrl.sv | 90 +++++++++
 tb/tb_pipe_hazard_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/PC-hold control with load-use bubbles, halt drain and stall counter
module pipe_hazard_ctrl #(
    parameter int NREG     = 4,
    parameter int LOAD_LAT = 1,
    parameter int BR_STG   = 2,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             jr_sel,
    input  logic             label_sel,
    input  logic             prediction,
    input  logic             lw_hazard,
    input  logic             hlt_id,
    input  logic             hlt_wb,
    input  logic             freeze,
    output logic             pc_hold,
    output logic [NREG-1:0]  stall,
    output logic [NREG-1:0]  flush,
    output logic             real_hlt,
    output logic [CNT_W-1:0] stall_cycles
);
    typedef enum logic [1:0] {RUN, LDSTALL, DRAIN, HALTED} state_t;
    localparam logic [NREG-1:0] BIT0 = NREG'(1);
    localparam logic [NREG-1:0] BIT1 = NREG'(2);
    localparam logic [NREG-1:0] LBL_MASK = {NREG{1'b1}} >> (NREG - BR_STG);
    state_t state, nextState;
    logic [2:0] lcnt, nextLcnt;
    logic redirect;
    logic [NREG-1:0] redirFlush;
    assign redirect   = jr_sel | prediction | label_sel;
    assign redirFlush = ((jr_sel | prediction) ? BIT0 : '0) | (label_sel ? LBL_MASK : '0);
    assign real_hlt   = state == HALTED;
    always_comb begin
        nextState = state;
        nextLcnt  = lcnt;
        pc_hold   = 1'b0;
        stall     = '0;
        flush     = '0;
        if (!rst_n) begin
            pc_hold = 1'b1;
            stall   = '1;
            flush   = '1;
        end else if (state == HALTED || freeze) begin
            pc_hold = 1'b1;
            stall   = '1;
        end else if (state == DRAIN) begin
            // a taken branch behind the halt means the halt was on the wrong path
            if (label_sel) begin
                flush     = LBL_MASK;
                nextState = RUN;
            end else begin
                pc_hold   = 1'b1;
                flush     = BIT0;
                nextState = hlt_wb ? HALTED : DRAIN;
            end
        end else if (redirect) begin
            flush     = redirFlush;
            nextState = RUN;
            nextLcnt  = '0;
        end else if (state == LDSTALL || lw_hazard) begin
            pc_hold = 1'b1;
            stall   = BIT0;
            flush   = BIT1;
            if (state == LDSTALL) begin
                nextLcnt  = lcnt - 3'd1;
                nextState = (lcnt <= 3'd1) ? RUN : LDSTALL;
            end else if (LOAD_LAT > 1) begin
                nextState = LDSTALL;
                nextLcnt  = 3'(LOAD_LAT - 1);
            end
        end else if (hlt_id) begin
            pc_hold   = 1'b1;
            stall     = BIT0;
            nextState = DRAIN;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= RUN;
            lcnt         <= '0;
            stall_cycles <= '0;
        end else begin
            state <= nextState;
            lcnt  <= nextLcnt;
            if (pc_hold && !freeze && state != HALTED && stall_cycles != '1)
                stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vector table plus randomized run against a behavioural model
module tb_pipe_hazard_ctrl;
    localparam int LL = 3;
    localparam logic [6:0] JR = 7'b1000000, LBL = 7'b0100000, PRED = 7'b0010000,
        LW = 7'b0001000, HID = 7'b0000100, HWB = 7'b0000010, FRZ = 7'b0000001;
    localparam logic [9:0] IDLE = 10'b0_0000_0000_0, BUB = 10'b1_0001_0010_0,
        FRZO = 10'b1_1111_0000_0, HOLD1 = 10'b1_0001_0000_0, DRN = 10'b1_0000_0001_0,
        HLT = 10'b1_1111_0000_1, LFL = 10'b0_0000_0011_0, F0 = 10'b0_0000_0001_0,
        RSTO = 10'b1_1111_1111_0;

    typedef struct {
        logic       rst;
        logic [6:0] in;
        logic [9:0] exp;
    } vec_t;

    logic clk = 1'b0, rst_n = 1'b0;
    logic jr_sel = 0, label_sel = 0, prediction = 0, lw_hazard = 0, hlt_id = 0, hlt_wb = 0, freeze = 0;
    logic pc_hold, real_hlt, pcHoldS, realHltS;
    logic [3:0] stall, flush, stallS, flushS, stallCyclesS;
    logic [15:0] stall_cycles;
    int tests = 0, fails = 0;

    bit mHalted, mDrain;
    int mBubbles, mCount;
    logic [9:0] eOut;
    vec_t vecs[$];

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.NREG(4), .LOAD_LAT(LL), .BR_STG(2), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .jr_sel(jr_sel), .label_sel(label_sel), .prediction(prediction),
        .lw_hazard(lw_hazard), .hlt_id(hlt_id), .hlt_wb(hlt_wb), .freeze(freeze),
        .pc_hold(pc_hold), .stall(stall), .flush(flush), .real_hlt(real_hlt), .stall_cycles(stall_cycles));

    pipe_hazard_ctrl #(.NREG(4), .LOAD_LAT(LL), .BR_STG(2), .CNT_W(4)) dutS (
        .clk(clk), .rst_n(rst_n), .jr_sel(jr_sel), .label_sel(label_sel), .prediction(prediction),
        .lw_hazard(lw_hazard), .hlt_id(hlt_id), .hlt_wb(hlt_wb), .freeze(freeze),
        .pc_hold(pcHoldS), .stall(stallS), .flush(flushS), .real_hlt(realHltS), .stall_cycles(stallCyclesS));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Expected outputs from the priority rules: halted > freeze > drain > redirect > bubble > halt
    task automatic modelEval();
        logic redir;
        redir = jr_sel | prediction | label_sel;
        eOut = IDLE;
        if (mHalted) eOut = HLT;
        else if (freeze) eOut = FRZO;
        else if (mDrain) eOut = label_sel ? LFL : DRN;
        else if (redir) eOut = {1'b0, 4'b0000, 2'b00, label_sel, label_sel | jr_sel | prediction, 1'b0};
        else if (mBubbles > 0 || lw_hazard) eOut = BUB;
        else if (hlt_id) eOut = HOLD1;
    endtask

    task automatic modelAdvance();
        if (eOut[9] && !freeze && !mHalted) mCount++;
        if (mHalted || freeze) begin
        end else if (mDrain) begin
            if (label_sel) mDrain = 0;
            else if (hlt_wb) begin
                mDrain  = 0;
                mHalted = 1;
            end
        end else if (jr_sel | prediction | label_sel) mBubbles = 0;
        else if (mBubbles > 0) mBubbles--;
        else if (lw_hazard) mBubbles = LL - 1;
        else if (hlt_id) mDrain = 1;
    endtask

    task automatic checkAll();
        modelEval();
        check("outs", {pc_hold, stall, flush, real_hlt}, 32'(eOut));
        check("outsS", {pcHoldS, stallS, flushS, realHltS}, 32'(eOut));
        check("cnt", 32'(stall_cycles), (mCount > 65535) ? 32'd65535 : 32'(mCount));
        check("cntS", 32'(stallCyclesS), (mCount > 15) ? 32'd15 : 32'(mCount));
    endtask

    task automatic step(input logic [6:0] in);
        @(negedge clk);
        {jr_sel, label_sel, prediction, lw_hazard, hlt_id, hlt_wb, freeze} = in;
        #1 checkAll();
        @(posedge clk);
        modelAdvance();
    endtask

    task automatic doReset();
        @(negedge clk);
        {jr_sel, label_sel, prediction, lw_hazard, hlt_id, hlt_wb, freeze} = '0;
        #2 rst_n = 1'b0;
        #1 check("rst_outs", {pc_hold, stall, flush, real_hlt}, 32'(RSTO));
        check("rst_outsS", {pcHoldS, stallS, flushS, realHltS}, 32'(RSTO));
        check("rst_cnt", 32'({stall_cycles, stallCyclesS}), 32'd0);
        #1 rst_n = 1'b1;
        mHalted = 0; mDrain = 0; mBubbles = 0; mCount = 0;
    endtask

    initial begin
        mHalted = 0; mDrain = 0; mBubbles = 0; mCount = 0;
        vecs.push_back('{1'b0, LW, BUB});   vecs.push_back('{1'b0, 7'd0, BUB});
        vecs.push_back('{1'b0, 7'd0, BUB}); vecs.push_back('{1'b0, 7'd0, IDLE});
        vecs.push_back('{1'b0, LW, BUB});   vecs.push_back('{1'b0, LBL, LFL});
        vecs.push_back('{1'b0, 7'd0, IDLE}); vecs.push_back('{1'b0, LW, BUB});
        for (int i = 0; i < 5; i++) vecs.push_back('{1'b0, FRZ, FRZO});
        vecs.push_back('{1'b0, 7'd0, BUB}); vecs.push_back('{1'b0, 7'd0, BUB});
        vecs.push_back('{1'b0, 7'd0, IDLE}); vecs.push_back('{1'b0, HID, HOLD1});
        vecs.push_back('{1'b0, 7'd0, DRN}); vecs.push_back('{1'b0, 7'd0, DRN});
        vecs.push_back('{1'b0, HWB, DRN});  vecs.push_back('{1'b0, 7'd0, HLT});
        vecs.push_back('{1'b0, LBL | JR | LW | FRZ, HLT});
        vecs.push_back('{1'b1, HID, HOLD1}); vecs.push_back('{1'b0, 7'd0, DRN});
        vecs.push_back('{1'b0, LBL, LFL});   vecs.push_back('{1'b0, JR | PRED, F0});
        vecs.push_back('{1'b0, LW | LBL, LFL}); vecs.push_back('{1'b0, HID, HOLD1});
        vecs.push_back('{1'b0, HID | LW | JR, DRN}); vecs.push_back('{1'b0, FRZ, FRZO});
        vecs.push_back('{1'b0, HWB | LBL, LFL}); vecs.push_back('{1'b0, 7'd0, IDLE});

        repeat (2) @(negedge clk);
        #1 check("init_outs", {pc_hold, stall, flush, real_hlt}, 32'(RSTO));
        check("init_cnt", 32'({stall_cycles, stallCyclesS}), 32'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            if (vecs[i].rst) doReset();
            step(vecs[i].in);
            check($sformatf("vec%0d", i), {pc_hold, stall, flush, real_hlt}, 32'(vecs[i].exp));
        end

        // saturation of the narrow counter, then async reset while halted
        doReset();
        repeat (20) step(LW);
        step(7'd0);
        check("sat_wide", 32'(stall_cycles), 32'd20);
        check("sat_narrow", 32'(stallCyclesS), 32'd15);
        step(7'd0); step(HID); step(7'd0); step(HWB); step(7'd0);
        check("halted", {real_hlt, realHltS}, 32'b11);
        doReset();
        step(7'd0);
        check("after_rst", {pc_hold, stall, flush, real_hlt, stall_cycles}, 32'd0);

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(99) == 0) doReset();
            else step({$urandom_range(99) < 10, $urandom_range(99) < 10, $urandom_range(99) < 8,
                       $urandom_range(99) < 25, $urandom_range(99) < 12, $urandom_range(99) < 20,
                       $urandom_range(99) < 10});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
